// File: rtl/ebus_arb.sv
// EBUS ownership arbiter: EBOX vs PI, with dead-time turnaround
// between owners and a hold-time watchdog that forces the bus free.
module ebus_arb #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int TURN_CYCLES    = 1
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             EBOX_REQ,
    input  logic             EBOX_REL,
    input  logic             PI_REQ,
    input  logic             PI_DONE,
    input  logic             TIMEOUT_CLR,
    output logic             EBOX_GRANT,
    output logic             PI_GRANT,
    output logic             BUS_IDLE,
    output logic [1:0]       OWNER,
    output logic             TIMEOUT,
    output logic             TIMEOUT_PI,
    output logic [CNT_W-1:0] HOLD_CNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EBOX = 2'b01,
        S_PI   = 2'b10,
        S_TURN = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = '1;
    localparam logic [1:0]       TURN_LAST = 2'(TURN_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_pi_q, last_pi_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       turn_q, turn_d;
    logic             timeout_q, timeout_d;
    logic             timeout_pi_q, timeout_pi_d;

    logic             pick_pi;
    logic             pick_ebox;
    logic             arb_open;
    logic             own_req;
    logic             own_rel;
    logic             normal_rel;
    logic             forced_rel;

    // Tie goes to PI unless PI was the last master granted.
    assign pick_pi   = PI_REQ && (!EBOX_REQ || !last_pi_q);
    assign pick_ebox = EBOX_REQ && !pick_pi;

    always_comb begin
        state_d      = state_q;
        last_pi_d    = last_pi_q;
        hold_d       = hold_q;
        turn_d       = turn_q;
        timeout_d    = timeout_q & ~TIMEOUT_CLR;
        timeout_pi_d = timeout_pi_q;

        arb_open   = (state_q == S_IDLE) ||
                     ((state_q == S_TURN) && (turn_q == TURN_LAST));
        own_req    = (state_q == S_PI) ? PI_REQ  : EBOX_REQ;
        own_rel    = (state_q == S_PI) ? PI_DONE : EBOX_REL;
        normal_rel = own_rel || !own_req;
        forced_rel = !normal_rel && (hold_q == HOLD_LAST);

        unique case (state_q)
            S_IDLE, S_TURN: begin
                if (state_q == S_TURN) begin
                    turn_d = turn_q + 2'd1;
                end
                if (arb_open) begin
                    if (pick_pi) begin
                        state_d   = S_PI;
                        last_pi_d = 1'b1;
                        hold_d    = '0;
                    end else if (pick_ebox) begin
                        state_d   = S_EBOX;
                        last_pi_d = 1'b0;
                        hold_d    = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_EBOX, S_PI: begin
                if (normal_rel || forced_rel) begin
                    state_d = S_TURN;
                    turn_d  = 2'd0;
                    hold_d  = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
                // A timeout set beats a same-cycle clear.
                if (forced_rel) begin
                    timeout_d    = 1'b1;
                    timeout_pi_d = (state_q == S_PI);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            last_pi_q    <= 1'b0;
            hold_q       <= '0;
            turn_q       <= 2'd0;
            timeout_q    <= 1'b0;
            timeout_pi_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_pi_q    <= last_pi_d;
            hold_q       <= hold_d;
            turn_q       <= turn_d;
            timeout_q    <= timeout_d;
            timeout_pi_q <= timeout_pi_d;
        end
    end

    assign EBOX_GRANT = (state_q == S_EBOX);
    assign PI_GRANT   = (state_q == S_PI);
    assign BUS_IDLE   = (state_q == S_IDLE);
    assign OWNER      = state_q;
    assign TIMEOUT    = timeout_q;
    assign TIMEOUT_PI = timeout_pi_q;
    assign HOLD_CNT   = hold_q;

endmodule
